// File: rtl/palette_data_out_if.sv
// Pixel/palette bus for palette_data_out: input pixel stream, palette write port,
// test-pattern select and the registered colour outputs.
interface palette_data_out_if #(
  parameter int PIX_W   = 8,
  parameter int COLOR_W = 8
);
  logic                   den;
  logic [PIX_W-1:0]       pixel;
  logic                   pal_we;
  logic [PIX_W-1:0]       pal_addr;
  logic [3*COLOR_W-1:0]   pal_wdata;
  logic                   test_mode;
  logic [COLOR_W-1:0]     R;
  logic [COLOR_W-1:0]     G;
  logic [COLOR_W-1:0]     B;
  logic                   den_out;

  modport master (
    output den, pixel, pal_we, pal_addr, pal_wdata, test_mode,
    input  R, G, B, den_out
  );

  modport slave (
    input  den, pixel, pal_we, pal_addr, pal_wdata, test_mode,
    output R, G, B, den_out
  );
endinterface

// File: rtl/palette_data_out.sv
// Palette lookup with a fixed 2-cycle pipeline from den/pixel to R/G/B/den_out.
// Optional colour-bar generator is built only when TEST_PATTERN_EN is defined.
module palette_data_out #(
  parameter int PIX_W   = 8,
  parameter int COLOR_W = 8,
  parameter int BAR_W   = 60
) (
  input  logic               clk_lcd,
  input  logic               rst_n,
  palette_data_out_if.slave  bus
);

  localparam int DEPTH = 1 << PIX_W;
  localparam int RGB_W = 3 * COLOR_W;

  function automatic logic [RGB_W-1:0] reset_entry(input int idx);
    logic [RGB_W-1:0] c;
    if (idx == 0)      c = '1;
    else if (idx == 1) c = '0;
    else               c = {{COLOR_W{1'b1}}, {(2*COLOR_W){1'b0}}};
    return c;
  endfunction

  logic [RGB_W-1:0] pal_mem [DEPTH];

  // Read in stage 1 sees the pre-write contents, so a same-cycle collision returns the old entry.
  always_ff @(posedge clk_lcd or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pal_mem[i] <= reset_entry(i);
    end else if (bus.pal_we) begin
      pal_mem[bus.pal_addr] <= bus.pal_wdata;
    end
  end

  // ---- stage 1: den and palette entry ----
  logic             vld_p1;
  logic [RGB_W-1:0] rgb_p1;

  always_ff @(posedge clk_lcd or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      rgb_p1 <= '0;
    end else begin
      vld_p1 <= bus.den;
      rgb_p1 <= pal_mem[bus.pixel];
    end
  end

  logic [RGB_W-1:0] pix_p1;

`ifdef TEST_PATTERN_EN
  localparam int COL_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      default: c = 3'b000;
    endcase
    return {{COLOR_W{c[2]}}, {COLOR_W{c[1]}}, {COLOR_W{c[0]}}};
  endfunction

  logic [COL_W-1:0] col_cnt;
  logic [2:0]       bar_cnt;
  logic [2:0]       bar_p1;
  logic             tm_line;
  logic             tm_p1;
  logic             line_start;

  // vld_p1 holds the previous den, so this marks a den rising edge at the input.
  assign line_start = bus.den & ~vld_p1;

  always_ff @(posedge clk_lcd or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      bar_cnt <= '0;
      bar_p1  <= '0;
      tm_line <= 1'b0;
      tm_p1   <= 1'b0;
    end else begin
      if (line_start) tm_line <= bus.test_mode;
      tm_p1  <= line_start ? bus.test_mode : tm_line;
      bar_p1 <= bar_cnt;
      if (!bus.den) begin
        col_cnt <= '0;
        bar_cnt <= '0;
      end else if (col_cnt == COL_W'(BAR_W - 1)) begin
        col_cnt <= '0;
        bar_cnt <= bar_cnt + 3'd1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  assign pix_p1 = tm_p1 ? bar_color(bar_p1) : rgb_p1;
`else
  logic unused_test_mode;
  assign unused_test_mode = bus.test_mode;
  assign pix_p1           = rgb_p1;
`endif

  // ---- stage 2: blanked colour and den_out ----
  logic             vld_p2;
  logic [RGB_W-1:0] rgb_p2;

  always_ff @(posedge clk_lcd or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      rgb_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      rgb_p2 <= vld_p1 ? pix_p1 : '0;
    end
  end

  assign bus.den_out = vld_p2;
  assign bus.R       = rgb_p2[3*COLOR_W-1 -: COLOR_W];
  assign bus.G       = rgb_p2[2*COLOR_W-1 -: COLOR_W];
  assign bus.B       = rgb_p2[COLOR_W-1   -: COLOR_W];

endmodule

// File: tb/tb_palette_data_out.sv
// Scoreboard bench for palette_data_out: driver pushes model predictions, monitor pops and compares.
module tb_palette_data_out;

  localparam int BAR_W = 4;
`ifdef TEST_PATTERN_EN
  localparam bit TP_BUILD = 1'b1;
`else
  localparam bit TP_BUILD = 1'b0;
`endif

  typedef struct {
    int          due;
    logic        d;
    logic [23:0] rgb;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_err;
  bit   mon_en;

  exp_t        q[$];
  logic [23:0] m_pal [256];
  logic        m_prev_den;
  logic        m_line_mode;
  int          m_n;
  logic [23:0] bars [8];

  logic        r_d, r_we, r_tm;
  logic [7:0]  r_pix, r_addr;
  logic [23:0] r_wd;

  palette_data_out_if #(.PIX_W(8), .COLOR_W(8)) bus ();

  palette_data_out #(.PIX_W(8), .COLOR_W(8), .BAR_W(BAR_W)) dut (
    .clk_lcd (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_reset();
    for (int i = 0; i < 256; i++)
      m_pal[i] = (i == 0) ? 24'hFFFFFF : (i == 1) ? 24'h000000 : 24'hFF0000;
    m_prev_den  = 1'b0;
    m_line_mode = 1'b0;
    m_n         = 0;
  endtask

  task automatic drive(input logic d, input logic [7:0] pix, input logic we,
                       input logic [7:0] addr, input logic [23:0] wd, input logic tm);
    logic [23:0] e;
    @(posedge clk);
    #1;
    bus.den       = d;
    bus.pixel     = pix;
    bus.pal_we    = we;
    bus.pal_addr  = addr;
    bus.pal_wdata = wd;
    bus.test_mode = tm;
    e = 24'h0;
    if (d && !m_prev_den) begin
      m_line_mode = tm;
      m_n         = 0;
    end
    if (d) begin
      e = (TP_BUILD && m_line_mode) ? bars[(m_n / BAR_W) % 8] : m_pal[pix];
      m_n++;
    end
    if (we) m_pal[addr] = wd;
    m_prev_den = d;
    q.push_back('{cyc + 2, d, e});
  endtask

  task automatic check_zero(input string tag);
    n_vec++;
    if ({bus.den_out, bus.R, bus.G, bus.B} !== 25'h0) begin
      n_err++;
      $display("FAIL %s: got den_out=%0b rgb=%02h%02h%02h, want den_out=0 rgb=000000",
               tag, bus.den_out, bus.R, bus.G, bus.B);
    end
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #3;
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_zero(tag);
    q.delete();
    model_reset();
    bus.den    = 1'b0;
    bus.pal_we = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en && q.size() != 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (bus.den_out !== e.d || {bus.R, bus.G, bus.B} !== e.rgb) begin
        n_err++;
        $display("FAIL pixel_out cyc=%0d: got den_out=%0b rgb=%02h%02h%02h, want den_out=%0b rgb=%06h",
                 cyc, bus.den_out, bus.R, bus.G, bus.B, e.d, e.rgb);
      end
    end
  end

  initial begin
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    n_vec = 0;
    n_err = 0;
    mon_en = 1'b0;
    rst_n = 1'b1;
    bus.den = 1'b0; bus.pixel = '0; bus.pal_we = 1'b0;
    bus.pal_addr = '0; bus.pal_wdata = '0; bus.test_mode = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_zero("reset_state");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Reset palette defaults then write collision and blanking sequences.
    drive(1, 8'h00, 0, 8'h00, 24'h0, 0);
    drive(1, 8'h01, 0, 8'h00, 24'h0, 0);
    drive(1, 8'h05, 0, 8'h00, 24'h0, 0);
    drive(1, 8'h05, 1, 8'h05, 24'h123456, 0);
    drive(1, 8'h05, 0, 8'h00, 24'h0, 0);
    drive(1, 8'h00, 0, 8'h00, 24'h0, 0);
    drive(0, 8'h00, 0, 8'h00, 24'h0, 0);
    drive(1, 8'h00, 0, 8'h00, 24'h0, 0);
    drive(0, 8'h05, 1, 8'h07, 24'hABCDEF, 0);
    drive(1, 8'h07, 0, 8'h00, 24'h0, 0);

    r_tm = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r_d   = ($urandom_range(0, 3) != 0);
      r_pix = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      r_we  = ($urandom_range(0, 2) == 0);
      r_addr = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      r_wd  = 24'($urandom);
      if ($urandom_range(0, 7) == 0) r_tm = ~r_tm;
      drive(r_d, r_pix, r_we, r_addr, r_wd, r_tm);
    end

    // Entry 5 is overwritten, then a mid-line reset must restore its default.
    drive(1, 8'h03, 1, 8'h05, 24'h0A0B0C, 0);
    drive(1, 8'h05, 0, 8'h00, 24'h0, 0);
    drive(1, 8'h06, 0, 8'h00, 24'h0, 0);
    async_reset("mid_line_reset");
    drive(1, 8'h05, 0, 8'h00, 24'h0, 0);
    drive(1, 8'h00, 0, 8'h00, 24'h0, 0);
    drive(1, 8'h01, 0, 8'h00, 24'h0, 0);
    drive(0, 8'h00, 0, 8'h00, 24'h0, 0);

    // Two 40-pixel lines with test_mode high, then one with it low.
    for (int ln = 0; ln < 3; ln++) begin
      for (int p = 0; p < 40; p++)
        drive(1, 8'($urandom), 0, 8'h00, 24'h0, (ln < 2));
      repeat (3) drive(0, 8'h00, 0, 8'h00, 24'h0, (ln < 1));
    end

    repeat (3) drive(0, 8'h00, 0, 8'h00, 24'h0, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected outputs never presented, want 0", q.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/palette_data_out.md
PALETTE_DATA_OUT -- requirements
Module: palette_data_out

Interface
REQ-001 Parameter PIX_W, default 8: pixel index width; palette depth is 2^PIX_W entries.
REQ-002 Parameter COLOR_W, default 8: width of each colour channel.
REQ-003 Parameter BAR_W, default 60: test-pattern bar width in active pixels.
REQ-004 clk_lcd  in  1: LCD pixel clock; all state updates on its rising edge.
REQ-005 rst_n  in  1: reset; asynchronous, active-low.
REQ-006 den  in  1: input data-enable; high marks an active pixel.
REQ-007 pixel  in  PIX_W: palette index, sampled together with den.
REQ-008 pal_we  in  1: palette write strobe.
REQ-009 pal_addr  in  PIX_W: palette write address.
REQ-010 pal_wdata  in  3*COLOR_W: write colour, packed {R,G,B}.
REQ-011 test_mode  in  1: selects colour-bar test pattern (TEST_PATTERN_EN builds only).
REQ-012 R, G, B  out  COLOR_W each: registered colour outputs.
REQ-013 den_out  out  1: den delayed to align with R/G/B.

Function
REQ-014 Fixed 2-cycle pipeline: stage 1 registers den and the palette entry at pixel; stage 2 registers R/G/B and den_out.
REQ-015 den_out in cycle n+2 equals den in cycle n, with no gaps or bubbles.
REQ-016 When stage-1 den is low, stage 2 drives R=G=B=0 (blanking), regardless of pixel.
REQ-017 Palette write: when pal_we is high at an edge, entry pal_addr takes pal_wdata after that edge.
REQ-018 Read/write collision: when pixel equals pal_addr in the write cycle, the lookup returns the old entry; the new value is visible from the next cycle.
REQ-019 Writes are accepted every cycle, independent of den; no busy or back-pressure.
REQ-020 Out-of-range data cannot occur; all indices 0..2^PIX_W-1 are valid.

Reset
REQ-021 rst_n low forces R=G=B=0 and den_out=0, and clears both pipeline stages immediately, without waiting for a clock edge.
REQ-022 Reset palette contents: entry 0 is all-ones (white); entry 1 is all-zeros (black); every other entry is {all-ones, 0, 0} (red).
REQ-023 Reset clears the test-pattern counters (REQ-025).
REQ-024 On rst_n deassertion, the first valid output appears 2 cycles after the first sampled den=1.

Configuration
REQ-025 With macro TEST_PATTERN_EN defined, the following SHALL apply:
- A column counter counts stage-1 active pixels and clears on each den falling edge.
- A bar index increments every BAR_W active pixels and wraps after 8 bars.
- When test_mode is high, stage 2 outputs bar colours in place of palette data: white, yellow, cyan, green, magenta, red, blue, black (full-scale channels).
- Blanking (REQ-016) still applies.
- test_mode changes take effect only at the next den rising edge.
REQ-026 Without TEST_PATTERN_EN, the following SHALL apply:
- No counters are built.
- test_mode is ignored.
- Outputs are always palette data.

Verification
REQ-027 Reset then den=1, pixel=0x00,0x01,0x05 -> outputs FFFFFF, 000000, FF0000 on cycles 3, 4, 5; den_out high from cycle 3.
REQ-028 pal_we=1, pal_addr=0x05, pal_wdata=0x123456 while pixel=0x05 -> next output is FF0000; pixel=0x05 one cycle later yields 123456.
REQ-029 den toggles 1,0,1 with pixel=0x00 -> outputs FFFFFF, 000000, FFFFFF; den_out=1,0,1, delayed 2 cycles.
REQ-030 Assert rst_n low mid-line, asynchronous to clk_lcd -> R/G/B/den_out are 0 before the next edge; a previously written palette entry reverts to its REQ-022 default.
REQ-031 TEST_PATTERN_EN, BAR_W=4, test_mode=1, 40 active pixels -> colour sequence steps every 4 pixels, wraps to white at pixel 32, and restarts at white on the next line.
